color_centroid_tracker: RTL and testbench

- Camera-domain pixel stage that feeds the IPU bus wrapper's async FIFO with one {present, row, col} result per frame.
- Classifies each valid RGB pixel against a colour threshold.
- Accumulates X/Y coordinate sums and a match count over the active frame.
- At frame end, computes the integer centroid with a shared sequential divider.

---
 rtl/color_centroid_tracker.sv | 213 +++++++++++++++++++++
 tb/tb_color_centroid_tracker.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/color_centroid_tracker.sv
// color_centroid_tracker
//
// Camera-domain pixel stage. Each valid in-frame RGB pixel is tested against
// a colour threshold (red high, green/blue low). Matching pixel coordinates
// are summed over the frame together with a match count. At the frame-end
// pixel the sums are snapshotted and a single shared restoring divider
// computes sumX/cnt and then sumY/cnt. The result is presented as one
// {present, row, col} strobe per frame for the downstream async FIFO.
//
// Optional feature macro: CENTROID_PIXCOUNT_EN
//   When defined, adds output oCount, which holds the match count of the
//   most recent result.
//
// Ports:
//   iCLK      camera pixel clock (only clock)
//   iRST      asynchronous active-low reset
//   iDVAL     pixel valid
//   iRed      red component   [11:0]
//   iGreen    green component [11:0]
//   iBlue     blue component  [11:0]
//   iX_Cont   pixel column    [10:0]
//   iY_Cont   pixel row       [10:0]
//   oRow      centroid row    [10:0]
//   oCol      centroid column [10:0]
//   oPresent  object detected in the last reported frame
//   oDVAL     one-cycle result strobe (FIFO write)
//   oOverrun  sticky: a frame ended while the divider was still busy
//   oCount    match count of the last result (CENTROID_PIXCOUNT_EN only)

module color_centroid_tracker #(
  parameter int          H_ACTIVE   = 640,
  parameter int          V_ACTIVE   = 480,
  parameter logic [11:0] R_MIN      = 12'd2048,
  parameter logic [11:0] G_MAX      = 12'd1024,
  parameter logic [11:0] B_MAX      = 12'd1024,
  parameter int          MIN_PIXELS = 16,
  parameter int          COUNT_W    = 19,
  parameter int          SUM_W      = 29
) (
  input  logic               iCLK,
  input  logic               iRST,
  input  logic               iDVAL,
  input  logic [11:0]        iRed,
  input  logic [11:0]        iGreen,
  input  logic [11:0]        iBlue,
  input  logic [10:0]        iX_Cont,
  input  logic [10:0]        iY_Cont,
  output logic [10:0]        oRow,
  output logic [10:0]        oCol,
  output logic               oPresent,
  output logic               oDVAL,
  output logic               oOverrun
`ifdef CENTROID_PIXCOUNT_EN
  ,
  output logic [COUNT_W-1:0] oCount
`endif
);

  localparam logic [10:0]         X_LIM   = 11'(H_ACTIVE);
  localparam logic [10:0]         Y_LIM   = 11'(V_ACTIVE);
  localparam logic [10:0]         X_END   = 11'(H_ACTIVE - 1);
  localparam logic [10:0]         Y_END   = 11'(V_ACTIVE - 1);
  localparam logic [COUNT_W-1:0]  MIN_CNT = COUNT_W'(MIN_PIXELS);
  localparam int                  BC_W    = $clog2(SUM_W);
  localparam logic [BC_W-1:0]     LAST_BIT = BC_W'(SUM_W - 1);

  typedef enum logic [1:0] {IDLE, DIV_X, DIV_Y, DONE} state_t;

  state_t             state;
  logic [SUM_W-1:0]   sum_x, sum_y;
  logic [COUNT_W-1:0] cnt;
  logic [SUM_W-1:0]   snap_x, snap_y;
  logic [COUNT_W-1:0] snap_cnt;
  logic [SUM_W-1:0]   quo;
  logic [COUNT_W-1:0] rem;
  logic [BC_W-1:0]    bit_cnt;
  logic [10:0]        quo_x;

  logic               match, frame_end, cnt_low;
  logic [SUM_W:0]     add_x, add_y;
  logic [COUNT_W:0]   add_c;
  logic [SUM_W-1:0]   frame_x, frame_y;
  logic [COUNT_W-1:0] frame_cnt;
  logic [COUNT_W-1:0] divisor;
  logic [COUNT_W:0]   trial;
  logic               ge;
  logic [COUNT_W-1:0] rem_next;
  logic [SUM_W-1:0]   quo_next;

  assign match = iDVAL && (iX_Cont < X_LIM) && (iY_Cont < Y_LIM) &&
                 (iRed >= R_MIN) && (iGreen <= G_MAX) && (iBlue <= B_MAX);
  assign frame_end = iDVAL && (iX_Cont == X_END) && (iY_Cont == Y_END);

  // Running sums including the current pixel; the carry-out bit of each
  // widened add detects overflow so the value pins at all-ones instead of
  // wrapping.
  always_comb begin
    add_x     = {1'b0, sum_x} + {{(SUM_W-10){1'b0}}, iX_Cont};
    add_y     = {1'b0, sum_y} + {{(SUM_W-10){1'b0}}, iY_Cont};
    add_c     = {1'b0, cnt} + (COUNT_W+1)'(1);
    frame_x   = sum_x;
    frame_y   = sum_y;
    frame_cnt = cnt;
    if (match) begin
      frame_x   = add_x[SUM_W]   ? '1 : add_x[SUM_W-1:0];
      frame_y   = add_y[SUM_W]   ? '1 : add_y[SUM_W-1:0];
      frame_cnt = add_c[COUNT_W] ? '1 : add_c[COUNT_W-1:0];
    end
  end

  // Too few pixels: the result is forced to zero anyway, so divide by one to
  // keep a zero divisor out of the datapath while keeping latency fixed.
  assign cnt_low = snap_cnt < MIN_CNT;
  assign divisor = cnt_low ? COUNT_W'(1) : snap_cnt;

  // One restoring-division step: bring down the next dividend bit, subtract
  // if it fits. The dividend register doubles as the quotient register.
  // rem < divisor always, so the low COUNT_W bits of the subtraction are exact.
  always_comb begin
    trial    = {rem, quo[SUM_W-1]};
    ge       = trial >= {1'b0, divisor};
    rem_next = ge ? (trial[COUNT_W-1:0] - divisor) : trial[COUNT_W-1:0];
    quo_next = {quo[SUM_W-2:0], ge};
  end

  // Accumulators run independently of the divider; the frame-end pixel's
  // contribution goes into the snapshot, so they simply restart at zero.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      sum_x <= '0;
      sum_y <= '0;
      cnt   <= '0;
    end else if (frame_end) begin
      sum_x <= '0;
      sum_y <= '0;
      cnt   <= '0;
    end else begin
      sum_x <= frame_x;
      sum_y <= frame_y;
      cnt   <= frame_cnt;
    end
  end

  // Control FSM, snapshot, divider and result registers.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      state    <= IDLE;
      snap_x   <= '0;
      snap_y   <= '0;
      snap_cnt <= '0;
      quo      <= '0;
      rem      <= '0;
      bit_cnt  <= '0;
      quo_x    <= '0;
      oRow     <= '0;
      oCol     <= '0;
      oPresent <= 1'b0;
      oDVAL    <= 1'b0;
      oOverrun <= 1'b0;
`ifdef CENTROID_PIXCOUNT_EN
      oCount   <= '0;
`endif
    end else begin
      oDVAL <= 1'b0;
      if (frame_end && state != IDLE)
        oOverrun <= 1'b1;
      case (state)
        IDLE: begin
          if (frame_end) begin
            snap_x   <= frame_x;
            snap_y   <= frame_y;
            snap_cnt <= frame_cnt;
            quo      <= frame_x;
            rem      <= '0;
            bit_cnt  <= '0;
            state    <= DIV_X;
          end
        end
        DIV_X: begin
          quo     <= quo_next;
          rem     <= rem_next;
          bit_cnt <= bit_cnt + BC_W'(1);
          if (bit_cnt == LAST_BIT) begin
            quo_x   <= quo_next[10:0];
            quo     <= snap_y;
            rem     <= '0;
            bit_cnt <= '0;
            state   <= DIV_Y;
          end
        end
        DIV_Y: begin
          quo     <= quo_next;
          rem     <= rem_next;
          bit_cnt <= bit_cnt + BC_W'(1);
          if (bit_cnt == LAST_BIT)
            state <= DONE;
        end
        DONE: begin
          oCol     <= cnt_low ? 11'd0 : quo_x;
          oRow     <= cnt_low ? 11'd0 : quo[10:0];
          oPresent <= !cnt_low;
          oDVAL    <= 1'b1;
`ifdef CENTROID_PIXCOUNT_EN
          oCount   <= snap_cnt;
`endif
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_color_centroid_tracker.sv
// Testbench for color_centroid_tracker: directed frames with hand-computed
// centroids. A second instance with an 8x2 frame exercises back-to-back
// frame ends and the overrun flag.

module tb_color_centroid_tracker;

  logic        iCLK = 1'b0;
  logic        iRST;
  logic        iDVAL;
  logic [11:0] iRed, iGreen, iBlue;
  logic [10:0] iX_Cont, iY_Cont;
  logic [10:0] oRow, oCol;
  logic        oPresent, oDVAL, oOverrun;

  logic        sDVAL;
  logic [11:0] sRed, sGreen, sBlue;
  logic [10:0] sX, sY;
  logic [10:0] sRow, sCol;
  logic        sPresent, sDVALo, sOverrun;

`ifdef CENTROID_PIXCOUNT_EN
  logic [18:0] oCount, sCount;
`endif

  int checks  = 0;
  int errors  = 0;
  int strobes = 0;

  always #5 iCLK = ~iCLK;

  color_centroid_tracker dut (
    .iCLK(iCLK), .iRST(iRST), .iDVAL(iDVAL),
    .iRed(iRed), .iGreen(iGreen), .iBlue(iBlue),
    .iX_Cont(iX_Cont), .iY_Cont(iY_Cont),
    .oRow(oRow), .oCol(oCol), .oPresent(oPresent),
    .oDVAL(oDVAL), .oOverrun(oOverrun)
`ifdef CENTROID_PIXCOUNT_EN
    , .oCount(oCount)
`endif
  );

  color_centroid_tracker #(.H_ACTIVE(8), .V_ACTIVE(2)) dut_small (
    .iCLK(iCLK), .iRST(iRST), .iDVAL(sDVAL),
    .iRed(sRed), .iGreen(sGreen), .iBlue(sBlue),
    .iX_Cont(sX), .iY_Cont(sY),
    .oRow(sRow), .oCol(sCol), .oPresent(sPresent),
    .oDVAL(sDVALo), .oOverrun(sOverrun)
`ifdef CENTROID_PIXCOUNT_EN
    , .oCount(sCount)
`endif
  );

  // Counts result strobes of the main instance, sampled mid-cycle.
  always @(negedge iCLK) if (oDVAL === 1'b1) strobes++;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int x, input int y, input int r,
                               input int g, input int b);
    iDVAL = 1'b1; iX_Cont = 11'(x); iY_Cont = 11'(y);
    iRed = 12'(r); iGreen = 12'(g); iBlue = 12'(b);
    @(negedge iCLK);
    iDVAL = 1'b0;
  endtask

  task automatic applySmall(input int x, input int y, input int r);
    sDVAL = 1'b1; sX = 11'(x); sY = 11'(y);
    sRed = 12'(r); sGreen = 12'd0; sBlue = 12'd0;
    @(negedge iCLK);
    sDVAL = 1'b0;
  endtask

  task automatic applyBlock(input int x0, input int y0, input int w, input int h);
    for (int y = y0; y < y0 + h; y++)
      for (int x = x0; x < x0 + w; x++)
        applyStimulus(x, y, 4000, 0, 0);
  endtask

  task automatic endFrame();
    applyStimulus(639, 479, 0, 0, 0);
  endtask

  // Called at the first negedge after the frame-end edge (sample 1, or
  // startK if more cycles have already elapsed). The strobe must appear at
  // sample 60 and last exactly one cycle.
  task automatic waitResult(input bit useSmall, input string tag, input int startK,
                            input int expCol, input int expRow, input int expPres,
                            input int expCnt);
    int lat;
    lat = 0;
    for (int k = startK; k <= 150; k++) begin
      if ((useSmall ? sDVALo : oDVAL) === 1'b1) begin
        lat = k;
        break;
      end
      @(negedge iCLK);
    end
    checkOutput({tag, ".latency"}, lat, 60);
    checkOutput({tag, ".col"}, useSmall ? sCol : oCol, expCol);
    checkOutput({tag, ".row"}, useSmall ? sRow : oRow, expRow);
    checkOutput({tag, ".present"}, useSmall ? sPresent : oPresent, expPres);
`ifdef CENTROID_PIXCOUNT_EN
    checkOutput({tag, ".count"}, useSmall ? sCount : oCount, expCnt);
`else
    if (expCnt < 0) $display("[TB] negative expected count in %s", tag);
`endif
    @(negedge iCLK);
    checkOutput({tag, ".strobe_width"}, useSmall ? sDVALo : oDVAL, 0);
  endtask

  initial begin
    int s0;
    iRST = 1'b0; iDVAL = 1'b0; iRed = '0; iGreen = '0; iBlue = '0;
    iX_Cont = '0; iY_Cont = '0;
    sDVAL = 1'b0; sRed = '0; sGreen = '0; sBlue = '0; sX = '0; sY = '0;

    // Reset state
    repeat (3) @(negedge iCLK);
    checkOutput("reset.row", oRow, 0);
    checkOutput("reset.col", oCol, 0);
    checkOutput("reset.present", oPresent, 0);
    checkOutput("reset.dval", oDVAL, 0);
    checkOutput("reset.overrun", oOverrun, 0);
    iRST = 1'b1;
    @(negedge iCLK);

    // 4x4 square at x=100..103, y=200..203: 1624/16=101, 3224/16=201
    $display("[TB] square object");
    applyBlock(100, 200, 4, 4);
    endFrame();
    waitResult(1'b0, "square", 1, 101, 201, 1, 16);

    // Reset mid-stream clears outputs at once; partial sums are discarded
    $display("[TB] reset mid-stream");
    applyBlock(300, 50, 4, 1);
    applyStimulus(300, 51, 4000, 0, 0);
    applyStimulus(301, 51, 4000, 0, 0);
    #2 iRST = 1'b0;
    #1;
    checkOutput("rst_stream.col", oCol, 0);
    checkOutput("rst_stream.row", oRow, 0);
    checkOutput("rst_stream.present", oPresent, 0);
    @(negedge iCLK);
    iRST = 1'b1;
    s0 = strobes;
    applyBlock(300, 50, 4, 4);
    repeat (10) @(negedge iCLK);
    checkOutput("rst_stream.no_strobe", strobes - s0, 0);
    // Sums 4824/16=301.5 and 824/16=51.5 floor to 301, 51
    endFrame();
    waitResult(1'b0, "rst_stream", 1, 301, 51, 1, 16);

    // Eight matches is below MIN_PIXELS
    $display("[TB] below threshold");
    applyBlock(10, 5, 8, 1);
    endFrame();
    waitResult(1'b0, "below", 1, 0, 0, 0, 8);

    // Threshold edges: 16 counted pixels on row 20 (x=40..55, sum 760),
    // plus rejects that would shift the centroid if counted
    $display("[TB] threshold edges");
    for (int x = 40; x <= 55; x++) begin
      if (x % 2 == 0) applyStimulus(x, 20, 2048, 1024, 1024);
      else            applyStimulus(x, 20, 4000, 0, 0);
    end
    for (int x = 0; x < 8; x++) begin
      case (x % 3)
        0:       applyStimulus(x, 100, 2047, 0, 0);
        1:       applyStimulus(x, 100, 4000, 1025, 0);
        default: applyStimulus(x, 100, 4000, 0, 1025);
      endcase
    end
    applyStimulus(650, 10, 4000, 0, 0);
    applyStimulus(5, 490, 4000, 0, 0);
    iX_Cont = 11'd600; iY_Cont = 11'd400; iRed = 12'd4000; iGreen = '0; iBlue = '0;
    @(negedge iCLK);
    endFrame();
    waitResult(1'b0, "thresh", 1, 47, 20, 1, 16);

    // Reset 20 cycles into the divide: that frame never reports
    $display("[TB] reset mid-divide");
    applyBlock(100, 200, 4, 4);
    endFrame();
    repeat (19) @(negedge iCLK);
    iRST = 1'b0;
    @(negedge iCLK);
    checkOutput("rst_div.present", oPresent, 0);
    checkOutput("rst_div.col", oCol, 0);
    iRST = 1'b1;
    s0 = strobes;
    repeat (80) @(negedge iCLK);
    checkOutput("rst_div.no_strobe", strobes - s0, 0);
    applyBlock(100, 200, 4, 4);
    endFrame();
    waitResult(1'b0, "rst_div_next", 1, 101, 201, 1, 16);

    // Overrun on the 8x2 instance. Frame 1 is all red:
    // sumX=56, sumY=8, cnt=16 -> col 3, row 0
    $display("[TB] overrun");
    for (int y = 0; y < 2; y++)
      for (int x = 0; x < 8; x++)
        applySmall(x, y, 4000);
    for (int y = 0; y < 2; y++)
      for (int x = 0; x < 8; x++)
        applySmall(x, y, 0);
    checkOutput("overrun.flag", sOverrun, 1);
    checkOutput("overrun.no_early_strobe", sDVALo, 0);
    waitResult(1'b1, "overrun.first", 17, 3, 0, 1, 16);
    // Frame after the divider returns to IDLE: 16 hits at (6,1) -> col 6, row 1
    for (int i = 0; i < 16; i++) applySmall(6, 1, 4000);
    applySmall(7, 1, 0);
    waitResult(1'b1, "overrun.next", 1, 6, 1, 1, 16);
    checkOutput("overrun.sticky", sOverrun, 1);
    checkOutput("main.no_overrun", oOverrun, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
